// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, stage-select encodings and product sign extension
// for the 16-tap convolution datapath and its controller.
package conv_pkg;
    localparam int PIX_W    = 8;
    localparam int COEF_W   = 8;
    localparam int NUM_TAPS = 16;
    localparam int PROD_W   = 17;
    localparam int ACC_W    = 21;

    typedef enum logic [4:0] {
        DP_IDLE = 5'b00000,
        DP_L4   = 5'b00001,
        DP_L3   = 5'b00010,
        DP_L2   = 5'b00100,
        DP_L1   = 5'b01000,
        DP_MULT = 5'b10000
    } dp_sel_e;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] x);
        return {{(ACC_W-PROD_W){x[PROD_W-1]}}, x};
    endfunction
endpackage

// File: rtl/conv_mul_u8s8.sv
// conv_mul_u8s8: unsigned pixel times signed coefficient, full-precision signed product.
module conv_mul_u8s8
    import conv_pkg::*;
(
    input  logic        [PIX_W-1:0]  pix,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [PROD_W-1:0] prod
);
    assign prod = $signed({1'b0, pix}) * coef;
endmodule

// File: rtl/conv_datapath.sv
// conv_datapath: two-word tap load, one shared multiply per cycle, then four
// in-place pairwise reduction stages ending in a registered 21-bit result.
module conv_datapath
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_valid,
    input  logic [63:0]             ram_data,
    input  logic [63:0]             rom_data,
    input  logic [4:0]              data_path_signal,
    output logic signed [ACC_W-1:0] result,
    output logic                    result_valid,
    output logic                    protocol_err
);
    logic        [PIX_W-1:0]  pix  [NUM_TAPS];
    logic signed [COEF_W-1:0] coef [NUM_TAPS];
    logic signed [ACC_W-1:0]  p    [NUM_TAPS];
    logic                     load_ptr;
    logic [4:0]               mult_idx;
    logic [4:0]               prev_sel;
    logic [4:0]               entry;
    logic                     legal;
    logic                     load;
    logic                     mult_we;
    logic [3:0]               widx;
    logic signed [PROD_W-1:0] prod;
    int                       add_lim;

    always_comb begin
        legal   = $onehot0(data_path_signal);
        entry   = data_path_signal & ~prev_sel;
        load    = data_valid && data_path_signal == DP_IDLE;
        widx    = entry == DP_MULT ? 4'd0 : mult_idx[3:0];
        mult_we = data_path_signal == DP_MULT && (entry == DP_MULT || mult_idx < 5'd16);
        add_lim = !legal          ? 0 :
                  entry == DP_L1  ? 8 :
                  entry == DP_L2  ? 4 :
                  entry == DP_L3  ? 2 :
                  entry == DP_L4  ? 1 : 0;
    end

    conv_mul_u8s8 u_mul (
        .pix  (pix[widx]),
        .coef (coef[widx]),
        .prod (prod)
    );

    // An illegal multi-hot select freezes everything but protocol_err, including stage history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                pix[k]  <= '0;
                coef[k] <= '0;
                p[k]    <= '0;
            end
            load_ptr     <= 1'b0;
            mult_idx     <= '0;
            prev_sel     <= DP_IDLE;
            result       <= '0;
            result_valid <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            protocol_err <= protocol_err | !legal | (data_valid && data_path_signal != DP_IDLE);
            result_valid <= legal && entry == DP_L4;
            if (legal)
                prev_sel <= data_path_signal;
            if (load) begin
                for (int k = 0; k < 8; k++) begin
                    pix[{load_ptr, 3'(k)}]  <= ram_data[8*k +: 8];
                    coef[{load_ptr, 3'(k)}] <= rom_data[8*k +: 8];
                end
                load_ptr <= ~load_ptr;
            end
            if (legal && entry == DP_MULT)
                load_ptr <= 1'b0;
            if (mult_we) begin
                p[widx]  <= sext_prod(prod);
                mult_idx <= 5'(widx) + 5'd1;
            end
            for (int i = 0; i < 8; i++)
                if (i < add_lim)
                    p[i] <= p[2*i] + p[2*i+1];
            if (legal && entry == DP_L4)
                result <= p[0] + p[1];
        end
    end
endmodule

// File: tb/tb_conv_datapath.sv
// tb_conv_datapath: scoreboard bench; expected sums are queued at L4 entry and
// popped whenever result_valid is seen.
module tb_conv_datapath;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               data_valid = 1'b0;
    logic [63:0]        ram_data = '0;
    logic [63:0]        rom_data = '0;
    logic [4:0]         data_path_signal = '0;
    logic signed [20:0] result;
    logic               result_valid;
    logic               protocol_err;

    logic        [7:0]  px [16];
    logic signed [7:0]  cf [16];
    logic signed [20:0] q [$];
    int                 checks = 0;
    int                 errors = 0;
    int                 rv_cnt = 0;

    conv_datapath dut (
        .clk              (clk),
        .reset            (reset),
        .data_valid       (data_valid),
        .ram_data         (ram_data),
        .rom_data         (rom_data),
        .data_path_signal (data_path_signal),
        .result           (result),
        .result_valid     (result_valid),
        .protocol_err     (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && result_valid) begin
            rv_cnt++;
            if (q.size() == 0)
                chk("unexpected_result_valid", 1, 0);
            else
                chk("result", result, q.pop_front());
        end
    end

    function automatic logic signed [20:0] model();
        int s = 0;
        for (int k = 0; k < 16; k++)
            s += int'(px[k]) * int'(cf[k]);
        return 21'(s);
    endfunction

    task automatic step(input logic dv, input logic [4:0] s, input logic [63:0] rd, input logic [63:0] cd);
        @(posedge clk);
        #1;
        data_valid       = dv;
        data_path_signal = s;
        ram_data         = rd;
        rom_data         = cd;
    endtask

    task automatic load_win();
        logic [63:0] rd;
        logic [63:0] cd;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 8; k++) begin
                rd[8*k +: 8] = px[8*w+k];
                cd[8*k +: 8] = cf[8*w+k];
            end
            step(1'b1, 5'b00000, rd, cd);
        end
        step(1'b0, 5'b00000, '0, '0);
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0: begin px[k] = 8'd1;         cf[k] = 8'sd1; end
                1: begin px[k] = 8'd255;       cf[k] = -8'sd128; end
                2: begin px[k] = 8'(k);        cf[k] = (k % 2 == 0) ? 8'sd1 : -8'sd1; end
                3: begin px[k] = 8'(k * 3);    cf[k] = 8'((k % 5) - 2); end
                default: begin px[k] = 8'd2;   cf[k] = 8'sd3; end
            endcase
        end
    endtask

    // glitch_at / dv_at: MULT cycle index at which to inject a multi-hot select or a stray load
    task automatic run_seq(input int glitch_at, input int dv_at);
        for (int i = 0; i < 16; i++) begin
            if (i == glitch_at) begin
                step(1'b0, 5'b11000, '0, '0);
                @(negedge clk);
                @(negedge clk);
                chk("glitch_perr", protocol_err, 1);
                chk("glitch_no_rv", result_valid, 0);
            end
            step(i == dv_at, 5'b10000, {64{i == dv_at}}, {64{i == dv_at}});
        end
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < 8; i++)
                step(1'b0, 5'b01000 >> n, '0, '0);
        q.push_back(model());
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 5'b00001, '0, '0);
            @(negedge clk);
            if (i == 0) chk("rv_before_edge", result_valid, 0);
            if (i == 1) chk("rv_pulse", result_valid, 1);
            if (i == 2) chk("rv_single", result_valid, 0);
        end
        step(1'b0, 5'b00000, '0, '0);
    endtask

    initial begin
        int rv0;
        #12;
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_perr", protocol_err, 0);
        @(negedge clk);
        reset = 1'b1;

        fill(0); load_win(); run_seq(-1, -1);
        fill(1); load_win(); run_seq(-1, -1);
        chk("min_value", result, -522240);
        fill(2); load_win(); run_seq(-1, -1);
        chk("alt_sign", result, -8);
        chk("perr_clean", protocol_err, 0);

        fill(3); load_win(); run_seq(8, -1);
        chk("perr_sticky", protocol_err, 1);

        fill(0); load_win();
        for (int i = 0; i < 8; i++)
            step(1'b0, 5'b10000, '0, '0);
        reset = 1'b0;
        #1;
        chk("async_result", result, 0);
        chk("async_rv", result_valid, 0);
        chk("async_perr", protocol_err, 0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 5'b00000, '0, '0);
        load_win(); run_seq(-1, -1);
        chk("post_reset", result, 16);

        fill(3); load_win(); run_seq(-1, 4);
        chk("stray_load_perr", protocol_err, 1);

        rv0 = rv_cnt;
        fill(0); load_win(); run_seq(-1, -1);
        fill(4); load_win();
        chk("result_held", result, 16);
        run_seq(-1, -1);
        chk("b2b_second", result, 96);
        chk("b2b_pulses", rv_cnt - rv0, 2);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
